i2s_adc_rx: RTL

- I2S serial receiver for the dock/cart audio ADC input (audio_adc). It is the receive-side counterpart of the core's I2S DAC generator.
- Oversamples externally supplied SCLK/LRCK/SDATA in the core clock domain and deserializes MSB-first two's-complement slots.
- Presents left/right sample pairs on a valid/ready interface for downstream audio logic.

---
 rtl/i2s_adc_rx.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx -- I2S serial receiver for the audio ADC input.
//
// Oversamples the asynchronous SCLK/LRCK/SDATA pins in the core clock domain
// and deserializes MSB-first two's-complement channel slots. Each completed
// left-then-right pair is presented on a valid/ready interface.
//
// Optional feature: define I2S_RX_FRAME_CHECK_EN to enable the slot-length
// check. Each slot must then be exactly SLOT_W bits long, and a bad slot sets
// the sticky frame_err and is dropped. When the macro is undefined, frame_err
// is tied to 0 and every L-then-R pair is emitted.
//
// Parameters:
//   DATA_W       captured bits per channel (DATA_W <= SLOT_W)
//   SLOT_W       nominal SCLK bits per channel slot
//   SYNC_STAGES  flops per input synchronizer (>= 2)
//
// Ports:
//   clk           core clock, at least 4x SCLK
//   reset_n       asynchronous active-low reset
//   i2s_sclk      bit clock (async)
//   i2s_lrck      word select, 0 = left, 1 = right (async)
//   i2s_sdata     serial data (async)
//   sample_l/r    presented sample pair
//   sample_valid  a pair is presented
//   sample_ready  consumer accepts the pair
//   overrun       sticky: a completed pair was dropped
//   overrun_clr   single-cycle clear of overrun (a same-cycle set wins)
//   frame_err     sticky slot-length error (check build only)
module i2s_adc_rx #(
    parameter int DATA_W      = 16,
    parameter int SLOT_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i2s_sclk,
    input  logic              i2s_lrck,
    input  logic              i2s_sdata,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(SLOT_W + 1);

    // Identical synchronizer chains keep the three pins mutually aligned.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
    logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;

    logic sclk_s, lrck_s, sdata_s, rise;

    // Deserializer state
    logic              synced_q, synced_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              lrck_q, lrck_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic              have_l_q, have_l_d;

    // Pair-complete event, registered between deserializer and output stage
    logic              pair_vld_q, pair_vld_d;
    logic [DATA_W-1:0] pair_l_q, pair_l_d;
    logic [DATA_W-1:0] pair_r_q, pair_r_d;

    // Output stage
    logic [DATA_W-1:0] sample_l_q, sample_l_d;
    logic [DATA_W-1:0] sample_r_q, sample_r_d;
    logic              sample_valid_q, sample_valid_d;
    logic              overrun_q, overrun_d;

    logic [DATA_W-1:0] sreg_bit;
    logic              slot_ok;
    logic              overrun_set;

`ifdef I2S_RX_FRAME_CHECK_EN
    logic frame_err_q, frame_err_d;
`endif

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign lrck_s  = lrck_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_prev_q;

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], i2s_sclk};
        lrck_sync_d  = {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], i2s_sdata};
        sclk_prev_d  = sclk_s;
    end

    // Shift register with the current bit written in. Only positions for
    // bit_cnt 0..DATA_W-1 exist, so surplus slot bits fall through untouched.
    always_comb begin
        sreg_bit = sreg_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt_q == CNT_W'(DATA_W - 1 - i)) begin
                sreg_bit[i] = sdata_s;
            end
        end
    end

    // The boundary rise carries the last bit of the old slot, so a full slot
    // has seen SLOT_W-1 mid-slot rises when the boundary arrives.
`ifdef I2S_RX_FRAME_CHECK_EN
    assign slot_ok = (bit_cnt_q == CNT_W'(SLOT_W - 1));
`else
    assign slot_ok = 1'b1;
`endif

    always_comb begin
        synced_d   = synced_q;
        bit_cnt_d  = bit_cnt_q;
        sreg_d     = sreg_q;
        lrck_d     = lrck_q;
        hold_l_d   = hold_l_q;
        have_l_d   = have_l_q;
        pair_vld_d = 1'b0;
        pair_l_d   = pair_l_q;
        pair_r_d   = pair_r_q;
`ifdef I2S_RX_FRAME_CHECK_EN
        frame_err_d = frame_err_q;
`endif
        if (rise) begin
            if (lrck_s == lrck_q) begin
                sreg_d = sreg_bit;
                if (bit_cnt_q != CNT_W'(SLOT_W)) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end else begin
                // The first boundary after reset only establishes alignment.
                if (!synced_q) begin
                    synced_d = 1'b1;
                end else if (!lrck_q) begin
                    have_l_d = slot_ok;
                    if (slot_ok) begin
                        hold_l_d = sreg_bit;
                    end
                end else begin
                    if (have_l_q && slot_ok) begin
                        pair_vld_d = 1'b1;
                        pair_l_d   = hold_l_q;
                        pair_r_d   = sreg_bit;
                    end
                    have_l_d = 1'b0;
                end
`ifdef I2S_RX_FRAME_CHECK_EN
                if (synced_q && !slot_ok) begin
                    frame_err_d = 1'b1;
                end
`endif
                lrck_d    = lrck_s;
                bit_cnt_d = '0;
                sreg_d    = '0;
            end
        end
    end

    // A new pair replaces the presented one only if the slot is free or being
    // accepted this cycle; otherwise it is dropped and flagged.
    always_comb begin
        sample_l_d     = sample_l_q;
        sample_r_d     = sample_r_q;
        sample_valid_d = sample_valid_q;
        overrun_set    = 1'b0;
        if (pair_vld_q) begin
            if (!sample_valid_q || sample_ready) begin
                sample_l_d     = pair_l_q;
                sample_r_d     = pair_r_q;
                sample_valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (sample_valid_q && sample_ready) begin
            sample_valid_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q    <= '0;
            lrck_sync_q    <= '0;
            sdata_sync_q   <= '0;
            sclk_prev_q    <= 1'b0;
            synced_q       <= 1'b0;
            bit_cnt_q      <= '0;
            sreg_q         <= '0;
            lrck_q         <= 1'b0;
            hold_l_q       <= '0;
            have_l_q       <= 1'b0;
            pair_vld_q     <= 1'b0;
            pair_l_q       <= '0;
            pair_r_q       <= '0;
            sample_l_q     <= '0;
            sample_r_q     <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            sclk_sync_q    <= sclk_sync_d;
            lrck_sync_q    <= lrck_sync_d;
            sdata_sync_q   <= sdata_sync_d;
            sclk_prev_q    <= sclk_prev_d;
            synced_q       <= synced_d;
            bit_cnt_q      <= bit_cnt_d;
            sreg_q         <= sreg_d;
            lrck_q         <= lrck_d;
            hold_l_q       <= hold_l_d;
            have_l_q       <= have_l_d;
            pair_vld_q     <= pair_vld_d;
            pair_l_q       <= pair_l_d;
            pair_r_q       <= pair_r_d;
            sample_l_q     <= sample_l_d;
            sample_r_q     <= sample_r_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;

endmodule
